// File: rtl/spi_sclk_sequencer_if.sv
// Request/status bundle between an SPI clock sequencer and its controller.
// SPI_CS_N is present only when SPI_SCLK_CS_EN is defined.
interface spi_sclk_sequencer_if;
   logic       start;
   logic [6:0] num_bits;
   logic       cpol;
   logic       cpha;
   logic       SPI_SCLK;
   logic       sample_strobe;
   logic       shift_strobe;
   logic       busy;
   logic       done;
   logic [7:0] CLOCK_CYCLES;
`ifdef SPI_SCLK_CS_EN
   logic       SPI_CS_N;

   modport master (
      output start, num_bits, cpol, cpha,
      input  SPI_SCLK, sample_strobe, shift_strobe, busy, done, CLOCK_CYCLES, SPI_CS_N
   );
   modport slave (
      input  start, num_bits, cpol, cpha,
      output SPI_SCLK, sample_strobe, shift_strobe, busy, done, CLOCK_CYCLES, SPI_CS_N
   );
`else
   modport master (
      output start, num_bits, cpol, cpha,
      input  SPI_SCLK, sample_strobe, shift_strobe, busy, done, CLOCK_CYCLES
   );
   modport slave (
      input  start, num_bits, cpol, cpha,
      output SPI_SCLK, sample_strobe, shift_strobe, busy, done, CLOCK_CYCLES
   );
`endif
endinterface

// File: rtl/spi_sclk_sequencer.sv
// SPI SCLK/strobe sequencer: done lands 1+HALF_PERIOD*(2N+1) cycles after start (+CS_SETUP+CS_HOLD with
// SPI_SCLK_CS_EN, which adds SPI_CS_N and LEAD/LAG); start is only taken in IDLE, there is no backpressure.
module spi_sclk_sequencer #(
   parameter int HALF_PERIOD = 3,
   parameter int CS_SETUP    = 2,
   parameter int CS_HOLD     = 2
) (
   input logic                 system_clock,
   input logic                 system_reset,
   spi_sclk_sequencer_if.slave bus
);

   if (HALF_PERIOD < 1 || HALF_PERIOD > 65535 ||
       CS_SETUP < 1 || CS_SETUP > 65535 || CS_HOLD < 1 || CS_HOLD > 65535) begin : g_param_check
      $error("spi_sclk_sequencer: timing parameter outside 1..65535");
   end

`ifdef SPI_SCLK_CS_EN
   typedef enum logic [2:0] {IDLE, LEAD, ACTIVE, TRAIL, LAG, DONE} state_t;
   localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
   localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
`else
   typedef enum logic [2:0] {IDLE, ACTIVE, TRAIL, DONE} state_t;
`endif
   localparam logic [15:0] HP_LAST = 16'(HALF_PERIOD - 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [6:0]  n_q, n_d;
   logic        cpha_q, cpha_d;
   logic        cpol_q, cpol_d;
   logic        sclk_q, sclk_d;
   logic        sample_q, sample_d;
   logic        shift_q, shift_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [7:0]  cc_q, cc_d;
`ifdef SPI_SCLK_CS_EN
   logic        cs_n_q, cs_n_d;
`endif

   logic       wrap;
   logic [7:0] edge_num;
   logic       last_edge;

   assign wrap      = (cnt_q == HP_LAST);
   assign edge_num  = cc_q + 8'd1;
   assign last_edge = (edge_num == {n_q, 1'b0});

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      n_d      = n_q;
      cpha_d   = cpha_q;
      cpol_d   = cpol_q;
      sclk_d   = sclk_q;
      sample_d = 1'b0;
      shift_d  = 1'b0;
      cc_d     = cc_q;
`ifdef SPI_SCLK_CS_EN
      cs_n_d   = cs_n_q;
`endif
      case (state_q)
         IDLE: begin
            // SCLK tracks the idle polarity so it already matches cpol_q when a frame starts
            cpol_d = bus.cpol;
            sclk_d = bus.cpol;
            cnt_d  = 16'd0;
            if (bus.start) begin
               n_d    = bus.num_bits;
               cpha_d = bus.cpha;
               cc_d   = 8'd0;
`ifdef SPI_SCLK_CS_EN
               state_d = LEAD;
               cs_n_d  = 1'b0;
`else
               state_d = (bus.num_bits == 7'd0) ? TRAIL : ACTIVE;
`endif
            end
         end
`ifdef SPI_SCLK_CS_EN
         LEAD: begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == SETUP_LAST) begin
               cnt_d   = 16'd0;
               state_d = (n_q == 7'd0) ? TRAIL : ACTIVE;
            end
         end
`endif
         ACTIVE: begin
            cnt_d = wrap ? 16'd0 : cnt_q + 16'd1;
            if (wrap) begin
               sclk_d = ~sclk_q;
               cc_d   = edge_num;
               // odd edges are leading edges; the final trailing edge never shifts
               if (cpha_q) begin
                  shift_d  = edge_num[0];
                  sample_d = ~edge_num[0];
               end else begin
                  sample_d = edge_num[0];
                  shift_d  = ~edge_num[0] & ~last_edge;
               end
               if (last_edge) begin
                  state_d = TRAIL;
               end
            end
         end
         TRAIL: begin
            cnt_d = wrap ? 16'd0 : cnt_q + 16'd1;
            if (wrap) begin
`ifdef SPI_SCLK_CS_EN
               state_d = LAG;
`else
               state_d = DONE;
`endif
            end
         end
`ifdef SPI_SCLK_CS_EN
         LAG: begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == HOLD_LAST) begin
               cnt_d   = 16'd0;
               state_d = DONE;
               cs_n_d  = 1'b1;
            end
         end
`endif
         DONE: begin
            cnt_d   = 16'd0;
            state_d = IDLE;
         end
         default: begin
            cnt_d   = 16'd0;
            state_d = IDLE;
         end
      endcase

`ifdef SPI_SCLK_CS_EN
      busy_d = (state_d == LEAD) || (state_d == ACTIVE) || (state_d == TRAIL) || (state_d == LAG);
`else
      busy_d = (state_d == ACTIVE) || (state_d == TRAIL);
`endif
      done_d = (state_d == DONE);
   end

   always_ff @(posedge system_clock) begin
      if (system_reset) begin
         state_q  <= IDLE;
         cnt_q    <= 16'd0;
         n_q      <= 7'd0;
         cpha_q   <= 1'b0;
         cpol_q   <= 1'b0;
         sclk_q   <= 1'b0;
         sample_q <= 1'b0;
         shift_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cc_q     <= 8'd0;
`ifdef SPI_SCLK_CS_EN
         cs_n_q   <= 1'b1;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         n_q      <= n_d;
         cpha_q   <= cpha_d;
         cpol_q   <= cpol_d;
         sclk_q   <= sclk_d;
         sample_q <= sample_d;
         shift_q  <= shift_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         cc_q     <= cc_d;
`ifdef SPI_SCLK_CS_EN
         cs_n_q   <= cs_n_d;
`endif
      end
   end

   assign bus.SPI_SCLK      = sclk_q;
   assign bus.sample_strobe = sample_q;
   assign bus.shift_strobe  = shift_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.CLOCK_CYCLES  = cc_q;
`ifdef SPI_SCLK_CS_EN
   assign bus.SPI_CS_N      = cs_n_q;
`endif

endmodule

// File: tb/tb_spi_sclk_sequencer.sv
// Directed bench for spi_sclk_sequencer: table of whole frames plus hand-written reset/priority sequences.
// Builds with or without SPI_SCLK_CS_EN.
module tb_spi_sclk_sequencer;
   localparam int HP = 3;
`ifdef SPI_SCLK_CS_EN
   localparam int LEAD_CYC = 2;
   localparam int CS_EXTRA = 4;
`else
   localparam int LEAD_CYC = 0;
   localparam int CS_EXTRA = 0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   spi_sclk_sequencer_if bus();

   spi_sclk_sequencer #(.HALF_PERIOD(HP), .CS_SETUP(2), .CS_HOLD(2)) dut (
      .system_clock(clk),
      .system_reset(rst),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] n;
      logic       pol;
      logic       pha;
      logic       disturb;
      int         lat;
      int         edges;
      int         samp;
      int         shft;
      logic       samp_rise;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_frame(input vec_t v, input string tag);
      int   cyc, lat, edges, samp, shft, wrong_dir, orphan, gap_bad, busy_bad, cs_bad;
      int   first_edge, last_edge_cyc, post_busy;
      logic prev_sclk, seen_done;
      lat = 0; edges = 0; samp = 0; shft = 0; wrong_dir = 0; orphan = 0; gap_bad = 0;
      busy_bad = 0; cs_bad = 0; first_edge = 0; last_edge_cyc = 0; post_busy = 0;
      @(negedge clk);
      bus.cpol = v.pol;
      bus.cpha = v.pha;
      bus.num_bits = v.n;
      @(negedge clk);
      check($sformatf("%s idle_sclk", tag), bus.SPI_SCLK, v.pol);
`ifdef SPI_SCLK_CS_EN
      check($sformatf("%s idle_cs_n", tag), bus.SPI_CS_N, 1);
`endif
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 1;
      prev_sclk = v.pol;
      seen_done = 1'b0;
      while (!seen_done && cyc < 2000) begin
         if (bus.SPI_SCLK != prev_sclk) begin
            edges++;
            if (first_edge == 0) first_edge = cyc;
            else if (cyc - last_edge_cyc != HP) gap_bad++;
            last_edge_cyc = cyc;
         end
         if (bus.sample_strobe) begin
            samp++;
            if (bus.SPI_SCLK == prev_sclk) orphan++;
            else if (bus.SPI_SCLK != v.samp_rise) wrong_dir++;
         end
         if (bus.shift_strobe) begin
            shft++;
            if (bus.SPI_SCLK == prev_sclk) orphan++;
            else if (bus.SPI_SCLK == v.samp_rise) wrong_dir++;
         end
         if (bus.done) begin
            seen_done = 1'b1;
            lat = cyc;
            check($sformatf("%s busy_in_done", tag), bus.busy, 0);
            check($sformatf("%s sclk_in_done", tag), bus.SPI_SCLK, v.pol);
`ifdef SPI_SCLK_CS_EN
            check($sformatf("%s cs_n_in_done", tag), bus.SPI_CS_N, 1);
`endif
         end else begin
            if (!bus.busy) busy_bad++;
`ifdef SPI_SCLK_CS_EN
            if (bus.SPI_CS_N !== 1'b0) cs_bad++;
`endif
         end
         prev_sclk = bus.SPI_SCLK;
         if (v.disturb) begin
            if (cyc == 10) begin
               bus.start = 1'b1;
               bus.num_bits = 7'd2;
               bus.cpha = ~v.pha;
               bus.cpol = ~v.pol;
            end
            if (cyc == 20) bus.start = 1'b0;
            if (seen_done) begin
               // start held through the DONE cycle must not launch a frame
               bus.start = 1'b1;
               bus.cpol = v.pol;
               bus.cpha = v.pha;
               bus.num_bits = v.n;
            end
         end
         if (!seen_done) begin
            @(negedge clk);
            cyc++;
         end
      end
      check($sformatf("%s done_latency", tag), lat, v.lat + CS_EXTRA);
      check($sformatf("%s edges", tag), edges, v.edges);
      check($sformatf("%s sample_strobes", tag), samp, v.samp);
      check($sformatf("%s shift_strobes", tag), shft, v.shft);
      check($sformatf("%s clock_cycles", tag), bus.CLOCK_CYCLES, v.edges);
      check($sformatf("%s strobe_wrong_edge", tag), wrong_dir, 0);
      check($sformatf("%s strobe_without_edge", tag), orphan, 0);
      check($sformatf("%s edge_spacing", tag), gap_bad, 0);
      check($sformatf("%s busy_drop", tag), busy_bad, 0);
`ifdef SPI_SCLK_CS_EN
      check($sformatf("%s cs_n_not_low", tag), cs_bad, 0);
`endif
      if (v.n != 7'd0) check($sformatf("%s first_edge", tag), first_edge, 1 + LEAD_CYC + HP);
      @(negedge clk);
      bus.start = 1'b0;
      check($sformatf("%s done_one_cycle", tag), bus.done, 0);
      for (int k = 0; k < 8; k++) begin
         if (bus.busy) post_busy++;
         @(negedge clk);
      end
      check($sformatf("%s no_second_frame", tag), post_busy, 0);
      check($sformatf("%s cc_held", tag), bus.CLOCK_CYCLES, v.edges);
   endtask

   initial begin
      int cyc, done_seen, busy_seen;
      //         n      pol   pha   dist  lat  edg  smp  shf  samp_rise
      vecs[0] = '{7'd8,   1'b0, 1'b0, 1'b0, 52,  16,  8,   7,   1'b1};
      vecs[1] = '{7'd4,   1'b1, 1'b1, 1'b0, 28,  8,   4,   4,   1'b1};
      vecs[2] = '{7'd0,   1'b0, 1'b0, 1'b0, 4,   0,   0,   0,   1'b1};
      vecs[3] = '{7'd1,   1'b1, 1'b0, 1'b0, 10,  2,   1,   0,   1'b0};
      vecs[4] = '{7'd3,   1'b0, 1'b1, 1'b0, 22,  6,   3,   3,   1'b0};
      vecs[5] = '{7'd127, 1'b0, 1'b0, 1'b0, 766, 254, 127, 126, 1'b1};
      vecs[6] = '{7'd8,   1'b0, 1'b0, 1'b1, 52,  16,  8,   7,   1'b1};

      rst = 1'b1;
      bus.start = 1'b0;
      bus.num_bits = 7'd0;
      bus.cpol = 1'b1;
      bus.cpha = 1'b0;
      repeat (3) @(negedge clk);
      check("reset sclk", bus.SPI_SCLK, 0);
      check("reset busy", bus.busy, 0);
      check("reset done", bus.done, 0);
      check("reset sample", bus.sample_strobe, 0);
      check("reset shift", bus.shift_strobe, 0);
      check("reset cc", bus.CLOCK_CYCLES, 0);
`ifdef SPI_SCLK_CS_EN
      check("reset cs_n", bus.SPI_CS_N, 1);
`endif
      rst = 1'b0;

      for (int i = 0; i < 7; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

      // reset outranks a simultaneous start
      @(negedge clk);
      bus.num_bits = 7'd4;
      bus.start = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.start = 1'b0;
      check("prio busy", bus.busy, 0);
      @(negedge clk);
      check("prio busy_after", bus.busy, 0);

      // reset on edge 5 of an N=8 frame abandons it without done
      bus.cpol = 1'b1;
      bus.cpha = 1'b0;
      bus.num_bits = 7'd8;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 0;
      while (bus.CLOCK_CYCLES != 8'd5 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("midreset reached_edge5", bus.CLOCK_CYCLES, 5);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midreset sclk", bus.SPI_SCLK, 0);
      check("midreset busy", bus.busy, 0);
      check("midreset cc", bus.CLOCK_CYCLES, 0);
      check("midreset done", bus.done, 0);
`ifdef SPI_SCLK_CS_EN
      check("midreset cs_n", bus.SPI_CS_N, 1);
`endif
      done_seen = 0;
      busy_seen = 0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (bus.done) done_seen++;
         if (bus.busy) busy_seen++;
      end
      check("midreset no_done", done_seen, 0);
      check("midreset stays_idle", busy_seen, 0);
      check("midreset idle_sclk_follows_cpol", bus.SPI_SCLK, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/spi_sclk_sequencer.md
SPI_SCLK_SEQUENCER -- requirements
Module: spi_sclk_sequencer

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 3, system_clock cycles per SCLK half-period, legal range 1..65535.
REQ-002 SHALL have parameter CS_SETUP, default 2, system_clock cycles between SPI_CS_N fall and the first half-period; used only with SPI_SCLK_CS_EN.
REQ-003 SHALL have parameter CS_HOLD, default 2, system_clock cycles between the end of the trailing half-period and SPI_CS_N rise; used only with SPI_SCLK_CS_EN.
REQ-004 SHALL have port system_clock, input, 1, the single clock.
REQ-005 SHALL have port system_reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, frame request, sampled only in IDLE.
REQ-007 SHALL have port num_bits, input, 7, bits per frame (0..127), latched on accepted start.
REQ-008 SHALL have port cpol, input, 1, SCLK idle level, latched as described in REQ-013.
REQ-009 SHALL have port cpha, input, 1, clock phase, latched on accepted start.
REQ-010 SHALL have the following output ports, all registered:
- SPI_SCLK, 1, serial clock.
- sample_strobe, 1, one-cycle pulse on a sample edge.
- shift_strobe, 1, one-cycle pulse on a shift edge.
- busy, 1, frame in progress.
- done, 1, one-cycle frame-complete pulse.
- CLOCK_CYCLES, 8, SCLK edges issued in the current or last frame.
- SPI_CS_N, 1, chip select; present only with SPI_SCLK_CS_EN.

Function
REQ-011 SHALL implement the states IDLE, LEAD, ACTIVE, TRAIL, LAG and DONE.
- LEAD and LAG exist only with SPI_SCLK_CS_EN.
- Transitions: IDLE->LEAD (or ACTIVE when CS is compiled out) on start; LEAD->ACTIVE after CS_SETUP cycles; ACTIVE->TRAIL on the 2*N-th edge; TRAIL->LAG (or DONE) after HALF_PERIOD cycles; LAG->DONE after CS_HOLD cycles; DONE->IDLE unconditionally after 1 cycle.
REQ-012 SHALL accept start only in IDLE; on acceptance it SHALL latch num_bits (N) and cpha, clear CLOCK_CYCLES, and assert busy from the next cycle.
REQ-013 SHALL register cpol into cpol_q every cycle while in IDLE and hold cpol_q otherwise; SPI_SCLK SHALL equal cpol_q in IDLE, LEAD, LAG and DONE.
REQ-014 SHALL run a 16-bit half-period counter in ACTIVE and TRAIL.
- The counter clears on entry and wraps from HALF_PERIOD-1 to 0.
- In ACTIVE, each wrap toggles SPI_SCLK and increments CLOCK_CYCLES.
REQ-015 SHALL issue exactly 2*N edges per frame; with N=0 it SHALL go directly from ACTIVE entry to TRAIL without toggling SPI_SCLK.
REQ-016 SHALL classify edges by number (1-based, odd = leading):
- With cpha=0: sample_strobe on odd edges; shift_strobe on even edges except edge 2*N.
- With cpha=1: shift_strobe on odd edges; sample_strobe on even edges.
REQ-017 SHALL assert each strobe in the same cycle that SPI_SCLK first shows the new level.
REQ-018 SHALL drive done high for exactly the DONE cycle, with busy low in that same cycle.
REQ-019 SHALL place done at cycle T+1+HALF_PERIOD*(2N+1), where start is accepted at edge T and CS is compiled out.
REQ-020 SHALL add CS_SETUP+CS_HOLD cycles to the REQ-019 latency when SPI_SCLK_CS_EN is defined.
REQ-021 SHALL ignore start, num_bits, cpha and cpol while busy; start high in DONE SHALL also be ignored.
REQ-022 SHALL hold CLOCK_CYCLES at its final value after the frame until the next accepted start.

Reset
REQ-023 SHALL, on system_reset, set the following reset values (the reset applies also mid-frame and the frame is abandoned without done):
- state = IDLE;
- cpol_q = 0 and SPI_SCLK = 0;
- sample_strobe = shift_strobe = busy = done = 0;
- CLOCK_CYCLES = 0;
- SPI_CS_N = 1;
- all counters = 0.
REQ-024 SHALL give system_reset priority over start in the same cycle.

Configuration
REQ-025 SHALL, when macro SPI_SCLK_CS_EN is defined, include port SPI_CS_N and states LEAD/LAG. SPI_CS_N SHALL go low on entry to LEAD and high on entry to DONE.
REQ-026 SHALL, when SPI_SCLK_CS_EN is undefined, omit SPI_CS_N, LEAD and LAG, and ignore CS_SETUP/CS_HOLD.

Verification
REQ-027 SHALL verify: HALF_PERIOD=3, N=8, cpol=0, cpha=0, no CS -> 16 edges, SCLK period 6 cycles, 8 sample_strobes, 7 shift_strobes, done at T+52, CLOCK_CYCLES=16.
REQ-028 SHALL verify: cpol=1, cpha=1, N=4 -> SCLK idles high, first edge falling, 4 shift_strobes on falling edges, 4 sample_strobes on rising edges.
REQ-029 SHALL verify: N=0 -> no SCLK edge, CLOCK_CYCLES=0, done at T+1+HALF_PERIOD.
REQ-030 SHALL verify: start re-asserted and num_bits changed mid-frame -> frame length unchanged, no second frame.
REQ-031 SHALL verify: system_reset pulsed on edge 5 of an N=8 frame -> next cycle SPI_SCLK=0, busy=0, CLOCK_CYCLES=0, no done.
REQ-032 SHALL verify: SPI_SCLK_CS_EN defined, CS_SETUP=2, CS_HOLD=2, N=8, HALF_PERIOD=3 -> SPI_CS_N low at T+1, first edge at T+6, done and SPI_CS_N high at T+56.
